// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the dual-issue queue: opcodes, queue entry type
// and instruction field/class helpers.
package riscv_pkg;

    localparam int IQ_XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [IQ_XLEN-1:0] inst;
        logic [IQ_XLEN-1:0] pc;
    } iq_entry_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    // Instructions that only the universal pipe (slot B) can execute.
    function automatic logic is_b_only(input logic [31:0] inst);
        logic [6:0] opc;
        opc = opcode_of(inst);
        return (opc == OPC_LOAD) || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
               (opc == OPC_JAL)  || (opc == OPC_JALR)  || (opc == OPC_SYSTEM);
    endfunction

    function automatic logic is_control(input logic [31:0] inst);
        logic [6:0] opc;
        opc = opcode_of(inst);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/dual_issue_queue_pair_check.sv
// Pairing rules for the two head entries: decides dual vs single issue and
// whether the younger instruction must take slot A (swap).
module pair_check
    import riscv_pkg::*;
(
    input  iq_entry_t h0,
    input  iq_entry_t h1,
    input  logic      h1_valid,
    output logic      dual,
    output logic      swap,
    output logic      raw_hazard
);

    logic h0_b_only;
    logic h1_b_only;
    logic unused_bits;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        h0_b_only  = is_b_only(h0.inst);
        h1_b_only  = is_b_only(h1.inst);
        // Plain field compare on every opcode; a false hazard only costs a single-issue.
        raw_hazard = h1_valid && (rd_of(h0.inst) != 5'd0) &&
                     ((rd_of(h0.inst) == rs1_of(h1.inst)) || (rd_of(h0.inst) == rs2_of(h1.inst)));
        dual       = h1_valid && !is_control(h0.inst) && !raw_hazard && !(h0_b_only && h1_b_only);
        swap       = dual && h0_b_only && !h1_b_only;
    end

    assign unused_bits = ^{h0.pc, h1.pc, h0.inst[31:12], h1.inst[31:25], h1.inst[14:7]};

endmodule

// File: rtl/dual_issue_queue.sv
// Fetch-to-decode instruction queue issuing up to two instructions per cycle.
// Define DUAL_ISSUE_PERF_EN to add saturating pair/single/empty/hazard counters.
module dual_issue_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = IQ_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_inst0,
    input  logic [XLEN-1:0] fetch_inst1,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            flush,
    input  logic            stall_d,
    output logic            issueA_valid,
    output logic            issueB_valid,
    output logic [XLEN-1:0] issueA_inst,
    output logic [XLEN-1:0] issueB_inst,
    output logic [XLEN-1:0] issueA_pc,
    output logic [XLEN-1:0] issueB_pc,
    output logic            issue_order
`ifdef DUAL_ISSUE_PERF_EN
   ,output logic [31:0]     perf_pair_cnt,
    output logic [31:0]     perf_single_cnt,
    output logic [31:0]     perf_empty_cnt,
    output logic [31:0]     perf_hazard_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    iq_entry_t     mem_q [DEPTH];

    iq_entry_t h0, h1;
    logic      head_valid, h1_valid;
    logic      dual, swap, raw_hazard;
    logic      push;
    logic [1:0] pop_cnt;

    assign h0          = mem_q[rptr_q];
    assign h1          = mem_q[rptr_q + PW'(1)];
    assign head_valid  = (count_q != '0);
    assign h1_valid    = (count_q >= CW'(2));
    assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(2);
    assign push        = fetch_valid && fetch_ready && !flush;

    pair_check u_pair_check (
        .h0         (h0),
        .h1         (h1),
        .h1_valid   (h1_valid),
        .dual       (dual),
        .swap       (swap),
        .raw_hazard (raw_hazard)
    );

    always_comb begin
        issueA_valid = 1'b0;
        issueB_valid = 1'b0;
        issueA_inst  = '0;
        issueB_inst  = '0;
        issueA_pc    = '0;
        issueB_pc    = '0;
        issue_order  = 1'b0;
        pop_cnt      = 2'd0;
        if (head_valid) begin
            issueB_valid = 1'b1;
            if (dual) begin
                issueA_valid = 1'b1;
                issue_order  = swap;
                issueA_inst  = swap ? h1.inst : h0.inst;
                issueA_pc    = swap ? h1.pc   : h0.pc;
                issueB_inst  = swap ? h0.inst : h1.inst;
                issueB_pc    = swap ? h0.pc   : h1.pc;
            end else begin
                issueB_inst  = h0.inst;
                issueB_pc    = h0.pc;
            end
            if (!stall_d && !flush) begin
                pop_cnt = dual ? 2'd2 : 2'd1;
            end
        end
    end

    always_comb begin
        wptr_d  = wptr_q + (push ? PW'(2) : PW'(0));
        rptr_d  = rptr_q + PW'(pop_cnt);
        count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop_cnt);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; count_q alone qualifies which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q]          <= '{inst: fetch_inst0, pc: fetch_pc};
            mem_q[wptr_q + PW'(1)] <= '{inst: fetch_inst1, pc: fetch_pc + XLEN'(4)};
        end
    end

`ifdef DUAL_ISSUE_PERF_EN
    logic [31:0] perf_pair_q, perf_pair_d;
    logic [31:0] perf_single_q, perf_single_d;
    logic [31:0] perf_empty_q, perf_empty_d;
    logic [31:0] perf_hazard_q, perf_hazard_d;
    logic        perf_active;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    assign perf_active = !stall_d && !flush;

    always_comb begin
        perf_pair_d   = perf_pair_q;
        perf_single_d = perf_single_q;
        perf_empty_d  = perf_empty_q;
        perf_hazard_d = perf_hazard_q;
        if (perf_active) begin
            if (pop_cnt == 2'd2) perf_pair_d   = sat_inc(perf_pair_q);
            if (pop_cnt == 2'd1) perf_single_d = sat_inc(perf_single_q);
            if (!head_valid)     perf_empty_d  = sat_inc(perf_empty_q);
            if (head_valid && !dual && raw_hazard) perf_hazard_d = sat_inc(perf_hazard_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_pair_q   <= '0;
            perf_single_q <= '0;
            perf_empty_q  <= '0;
            perf_hazard_q <= '0;
        end else begin
            perf_pair_q   <= perf_pair_d;
            perf_single_q <= perf_single_d;
            perf_empty_q  <= perf_empty_d;
            perf_hazard_q <= perf_hazard_d;
        end
    end

    assign perf_pair_cnt   = perf_pair_q;
    assign perf_single_cnt = perf_single_q;
    assign perf_empty_cnt  = perf_empty_q;
    assign perf_hazard_cnt = perf_hazard_q;
`else
    logic unused_raw;
    assign unused_raw = raw_hazard;
`endif

endmodule

// File: tb/tb_dual_issue_queue.sv
// Self-checking bench for dual_issue_queue: directed pairing table, full/flush/reset
// sequences and randomized traffic against a queue-based reference model.
module tb_dual_issue_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_inst0, fetch_inst1, fetch_pc;
    logic            flush, stall_d;
    logic            issueA_valid, issueB_valid;
    logic [XLEN-1:0] issueA_inst, issueB_inst, issueA_pc, issueB_pc;
    logic            issue_order;

    always #5 clk = ~clk;

    dual_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_inst0  (fetch_inst0),
        .fetch_inst1  (fetch_inst1),
        .fetch_pc     (fetch_pc),
        .flush        (flush),
        .stall_d      (stall_d),
        .issueA_valid (issueA_valid),
        .issueB_valid (issueB_valid),
        .issueA_inst  (issueA_inst),
        .issueB_inst  (issueB_inst),
        .issueA_pc    (issueA_pc),
        .issueB_pc    (issueB_pc),
        .issue_order  (issue_order)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
        return {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_sub(input int rd, input int rs1, input int rs2);
        return {7'b0100000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] i_sw(input int rs2, input int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] i_beq(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] i_jal(input int rd);
        return {20'h00400, 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] i_jalr(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
    endfunction
    localparam logic [31:0] I_ECALL = 32'h0000_0073;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        bit          av, bv, ord;
        logic [31:0] ai, ap, bi, bp;
        int          npop;
    } exp_t;

    ent_t q[$];
    bit   last_acc = 1'b1;

    function automatic bit b_only(input logic [31:0] i);
        logic [6:0] o;
        o = i[6:0];
        return o inside {7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};
    endfunction
    function automatic bit ctrl(input logic [31:0] i);
        logic [6:0] o;
        o = i[6:0];
        return o inside {7'b1100011, 7'b1101111, 7'b1100111};
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        ent_t x, y;
        bit   single;
        e = '{default: 0};
        if (q.size() == 0) return e;
        x = q[0];
        single = (q.size() == 1);
        if (!single) begin
            y = q[1];
            single = ctrl(x.inst) ||
                     (x.inst[11:7] != 0 && (x.inst[11:7] == y.inst[19:15] || x.inst[11:7] == y.inst[24:20])) ||
                     (b_only(x.inst) && b_only(y.inst));
        end
        e.bv = 1;
        if (single) begin
            e.bi = x.inst; e.bp = x.pc; e.npop = 1;
        end else begin
            e.av = 1; e.npop = 2;
            if (!b_only(y.inst) && b_only(x.inst)) begin
                e.ai = y.inst; e.ap = y.pc; e.bi = x.inst; e.bp = x.pc; e.ord = 1;
            end else begin
                e.ai = x.inst; e.ap = x.pc; e.bi = y.inst; e.bp = y.pc;
            end
        end
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        exp_t e;
        e = model_expect();
        check({tag, " ready"},   fetch_ready, (DEPTH - q.size()) >= 2);
        check({tag, " a_valid"}, issueA_valid, e.av);
        check({tag, " b_valid"}, issueB_valid, e.bv);
        check({tag, " a_inst"},  issueA_inst, e.ai);
        check({tag, " a_pc"},    issueA_pc, e.ap);
        check({tag, " b_inst"},  issueB_inst, e.bi);
        check({tag, " b_pc"},    issueB_pc, e.bp);
        check({tag, " order"},   issue_order, e.ord);
    endtask

    // Advance one clock edge, applying the current inputs to the model.
    task automatic step();
        exp_t e;
        bit   acc;
        e   = model_expect();
        acc = fetch_valid && ((DEPTH - q.size()) >= 2) && !flush;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (!stall_d) repeat (e.npop) void'(q.pop_front());
            if (acc) begin
                q.push_back('{fetch_inst0, fetch_pc});
                q.push_back('{fetch_inst1, fetch_pc + 32'd4});
            end
        end
        last_acc = acc || flush;
        #1;
    endtask

    task automatic cycle(input string tag);
        check_outputs(tag);
        step();
    endtask

    task automatic drain();
        fetch_valid = 0; stall_d = 0; flush = 0;
        for (int k = 0; k < 16 && q.size() != 0; k++) cycle("drain");
        check("drain empty", issueB_valid, 1'b0);
    endtask

    task automatic push_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        fetch_valid = 1; fetch_inst0 = i0; fetch_inst1 = i1; fetch_pc = pc;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] i0, i1;
        bit          av, ord;
        logic [31:0] ai, ap, bi, bp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] rand_inst();
        int r1, r2, r3;
        r1 = $urandom_range(0, 3); r2 = $urandom_range(0, 3); r3 = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return i_add(r1, r2, r3);
            4: return i_lw(r1, r2);
            5: return i_sw(r1, r2);
            6: return i_beq(r1, r2);
            7: return i_jal(r1);
            8: return i_jalr(r1, r2);
            default: return I_ECALL;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{i_add(1,2,3), i_add(4,5,6), 1, 0, i_add(1,2,3), 32'h100, i_add(4,5,6), 32'h104};
        vecs[1]  = '{i_add(1,2,3), i_sub(7,1,2), 0, 0, 32'h0, 32'h0, i_add(1,2,3), 32'h100};
        vecs[2]  = '{i_add(3,1,2), i_lw(5,6),    1, 0, i_add(3,1,2), 32'h100, i_lw(5,6), 32'h104};
        vecs[3]  = '{i_lw(5,6),    i_add(7,8,9), 1, 1, i_add(7,8,9), 32'h104, i_lw(5,6), 32'h100};
        vecs[4]  = '{i_beq(1,2),   i_add(3,4,5), 0, 0, 32'h0, 32'h0, i_beq(1,2), 32'h100};
        vecs[5]  = '{i_lw(5,6),    i_sw(7,8),    0, 0, 32'h0, 32'h0, i_lw(5,6), 32'h100};
        vecs[6]  = '{i_add(0,1,2), i_add(3,0,0), 1, 0, i_add(0,1,2), 32'h100, i_add(3,0,0), 32'h104};
        vecs[7]  = '{i_jal(1),     i_add(1,2,3), 0, 0, 32'h0, 32'h0, i_jal(1), 32'h100};
        vecs[8]  = '{i_add(2,3,4), i_lw(5,2),    0, 0, 32'h0, 32'h0, i_add(2,3,4), 32'h100};
        vecs[9]  = '{I_ECALL,      i_add(5,6,7), 1, 1, i_add(5,6,7), 32'h104, I_ECALL, 32'h100};
        vecs[10] = '{i_add(1,2,3), i_add(4,5,1), 0, 0, 32'h0, 32'h0, i_add(1,2,3), 32'h100};

        reset = 1; fetch_valid = 0; fetch_inst0 = 0; fetch_inst1 = 0; fetch_pc = 0;
        flush = 0; stall_d = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready",   fetch_ready, 1'b1);
        check("reset a_valid", issueA_valid, 1'b0);
        check("reset b_valid", issueB_valid, 1'b0);
        check("reset outputs", {issueA_inst, issueB_inst, issueA_pc, issueB_pc, issue_order}, '0);
        reset = 0;
        cycle("idle");

        // Pairing table: push one pair, check the first issue cycle, then drain.
        for (int v = 0; v < 11; v++) begin
            push_pair(vecs[v].i0, vecs[v].i1, 32'h100);
            step();
            fetch_valid = 0;
            check($sformatf("vec%0d a_valid", v), issueA_valid, vecs[v].av);
            check($sformatf("vec%0d b_valid", v), issueB_valid, 1'b1);
            check($sformatf("vec%0d a_inst", v),  issueA_inst, vecs[v].ai);
            check($sformatf("vec%0d a_pc", v),    issueA_pc, vecs[v].ap);
            check($sformatf("vec%0d b_inst", v),  issueB_inst, vecs[v].bi);
            check($sformatf("vec%0d b_pc", v),    issueB_pc, vecs[v].bp);
            check($sformatf("vec%0d order", v),   issue_order, vecs[v].ord);
            drain();
        end

        // Fill under stall, hold a rejected pair, then release and drain two per cycle.
        stall_d = 1;
        push_pair(i_add(1,2,3), i_add(4,5,6), 32'h200);
        cycle("full push1");
        push_pair(i_add(8,9,10), i_add(11,12,13), 32'h208);
        cycle("full push2");
        check("full ready", fetch_ready, 1'b0);
        push_pair(i_add(14,15,16), i_add(17,18,19), 32'h210);
        cycle("full hold");
        fetch_valid = 0; stall_d = 0;
        check("full drain1 both", {issueA_valid, issueB_valid}, 2'b11);
        check("full drain1 a_pc", issueA_pc, 32'h200);
        cycle("full drain1");
        check("full ready back", fetch_ready, 1'b1);
        check("full drain2 a_pc", issueA_pc, 32'h208);
        drain();

        // Flush with a full queue and a pair offered in the same cycle.
        stall_d = 1;
        push_pair(i_add(1,2,3), i_add(4,5,6), 32'h300);
        cycle("fl push1");
        push_pair(i_add(8,9,10), i_add(11,12,13), 32'h308);
        cycle("fl push2");
        push_pair(i_add(20,21,22), i_add(23,24,25), 32'h310);
        flush = 1;
        cycle("fl flush");
        flush = 0; fetch_valid = 0;
        check("flush valids", {issueA_valid, issueB_valid}, 2'b00);
        check("flush ready", fetch_ready, 1'b1);
        cycle("fl after");
        check("flush not stored", issueB_valid, 1'b0);
        stall_d = 0;

        // Asynchronous reset mid-operation.
        stall_d = 1;
        push_pair(i_add(1,2,3), i_add(4,5,6), 32'h400);
        cycle("rst push");
        fetch_valid = 0;
        #3 reset = 1;
        #1;
        check("midrst b_valid", issueB_valid, 1'b0);
        check("midrst ready", fetch_ready, 1'b1);
        q.delete();
        @(posedge clk);
        #1 reset = 0;
        stall_d = 0;
        cycle("post rst");

        // Randomized traffic against the model; offered data held until accepted.
        for (int n = 0; n < 500; n++) begin
            if (!(fetch_valid && !last_acc)) begin
                fetch_valid = ($urandom_range(0, 2) != 0);
                fetch_inst0 = rand_inst();
                fetch_inst1 = rand_inst();
                fetch_pc    = $urandom() & 32'hFFFF_FFFC;
            end
            stall_d = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
